// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver (start, 8 data LSB first, stop) with a two-flop
//            input synchronizer and a sticky byte-ready flag. BAUD_CNT >= 4.
//            Define UART_RX_FRM_ERR_EN to add the frm_err stop-bit check output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int BAUD_CNT = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
`ifdef UART_RX_FRM_ERR_EN
    ,
    output logic       frm_err
`endif
);

    localparam int                 c_CNT_W     = $clog2(BAUD_CNT);
    localparam logic [c_CNT_W-1:0] c_HALF_BIT  = c_CNT_W'(BAUD_CNT / 2);
    localparam logic [c_CNT_W-1:0] c_FULL_BIT  = c_CNT_W'(BAUD_CNT - 1);
    localparam logic [3:0]         c_START_SMP = 4'd0;
    localparam logic [3:0]         c_STOP_SMP  = 4'd9;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RECEIVE = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic                 r_rx_prev;

    logic [c_CNT_W-1:0]   r_baud_cnt;
    logic [3:0]           r_bit_cnt;
    logic [7:0]           r_shift;
    logic [7:0]           r_rx_data;
    logic                 r_rdy;

    logic                 w_start;
    logic                 w_strobe;
    logic                 w_frame_done;

    // Synchronizer flops reset high so reset release never looks like a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Start requires a falling edge, so a held-low line (break) cannot retrigger
    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_strobe     = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_rx_prev && !r_rx_s) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_RECEIVE;
                end
            end
            ST_RECEIVE: begin
                if (r_baud_cnt == '0) begin
                    w_strobe = 1'b1;
                    if ((r_bit_cnt == c_START_SMP) && r_rx_s) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_bit_cnt == c_STOP_SMP) begin
                        w_state_nxt  = ST_IDLE;
                        w_frame_done = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Half-bit initial load puts every later sample at the middle of its bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'h00;
        end else if (w_start) begin
            r_baud_cnt <= c_HALF_BIT;
            r_bit_cnt  <= 4'd0;
        end else if (r_state == ST_RECEIVE) begin
            if (w_strobe) begin
                r_baud_cnt <= c_FULL_BIT;
                r_bit_cnt  <= r_bit_cnt + 4'd1;
                if ((r_bit_cnt != c_START_SMP) && (r_bit_cnt != c_STOP_SMP)) begin
                    r_shift <= {r_rx_s, r_shift[7:1]};
                end
            end else begin
                r_baud_cnt <= r_baud_cnt - 1'b1;
            end
        end
    end

    // Frame completion outranks clr_rdy so a byte is never silently lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data <= 8'h00;
            r_rdy     <= 1'b0;
        end else if (w_frame_done) begin
            r_rx_data <= r_shift;
            r_rdy     <= 1'b1;
        end else if (clr_rdy || w_start) begin
            r_rdy     <= 1'b0;
        end
    end

    assign rx_data = r_rx_data;
    assign rdy     = r_rdy;

`ifdef UART_RX_FRM_ERR_EN
    logic r_frm_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frm_err <= 1'b0;
        end else if (w_frame_done) begin
            r_frm_err <= ~r_rx_s;
        end
    end

    assign frm_err = r_frm_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// Testbench for uart_rx: a fast-baud instance under a queue-based frame model
// and per-cycle scoreboard, plus a default-baud instance for the latency check.
module tb_uart_rx;

    localparam int PERIOD = 10;
    localparam int B      = 16;
    localparam int BF     = 2604;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       rx    = 1'b1;
    logic       clr   = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;

    logic       rst_f = 1'b0;
    logic       rx_f  = 1'b1;
    logic       clr_f = 1'b0;
    logic [7:0] rx_data_f;
    logic       rdy_f;

`ifdef UART_RX_FRM_ERR_EN
    logic       frm_err;
    logic       frm_err_f;
`endif

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        longint     t_fall;
    } exp_t;

    exp_t q[$];
    logic rand_clr_en = 1'b0;

    always #(PERIOD/2) clk = ~clk;

    uart_rx #(.BAUD_CNT(B)) dut (
        .clk     (clk),
        .rst     (rst),
        .RX      (rx),
        .clr_rdy (clr),
        .rx_data (rx_data),
        .rdy     (rdy)
`ifdef UART_RX_FRM_ERR_EN
        ,
        .frm_err (frm_err)
`endif
    );

    uart_rx dut_full (
        .clk     (clk),
        .rst     (rst_f),
        .RX      (rx_f),
        .clr_rdy (clr_f),
        .rx_data (rx_data_f),
        .rdy     (rdy_f)
`ifdef UART_RX_FRM_ERR_EN
        ,
        .frm_err (frm_err_f)
`endif
    );

    // Cycles from the RX falling edge to rdy rising: sync + half bit + 9 bits + 1
    function automatic int lat_model(input int b);
        return 2 + b / 2 + 9 * b + 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic stop);
        exp_t e;
        e.data   = d;
        e.stop   = stop;
        e.t_fall = longint'($time);
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input int gap);
        push_exp(d, stop);
        rx = 1'b0;
        wait_cyc(B);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_cyc(B);
        end
        rx = stop;
        wait_cyc(B);
        rx = 1'b1;
        wait_cyc(gap);
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int i = 0; i < max_cyc && q.size() != 0; i++) begin
            wait_cyc(1);
        end
        check("queue_drained", 32'(q.size()), 32'(0));
    endtask

    // Scoreboard for the fast instance, evaluated on every falling clock edge
    logic       sb_prev_rdy  = 1'b0;
    logic       sb_prev_clr  = 1'b0;
    logic       sb_prev_rx   = 1'b1;
    logic [7:0] sb_prev_data = 8'h00;
    logic       sb_prev_fe   = 1'b0;
    longint     sb_last_fall = -1000;

    initial begin : scoreboard
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("reset_rdy", 32'(rdy), 32'(0));
                check("reset_rx_data", 32'(rx_data), 32'(0));
`ifdef UART_RX_FRM_ERR_EN
                check("reset_frm_err", 32'(frm_err), 32'(0));
`endif
                q.delete();
                sb_prev_rdy  = 1'b0;
                sb_prev_data = 8'h00;
                sb_prev_fe   = 1'b0;
            end else begin
                if (!rx && sb_prev_rx) begin
                    sb_last_fall = longint'($time);
                end
                if (rdy && !sb_prev_rdy) begin
                    if (q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_rdy: got rx_data 0x%0h, expected no delivery", rx_data);
                    end else begin
                        e = q.pop_front();
                        check("rx_data", 32'(rx_data), 32'(e.data));
                        check_range("latency",
                            int'((longint'($time) - PERIOD/2 - e.t_fall) / PERIOD),
                            lat_model(B) - 1, lat_model(B) + 1);
`ifdef UART_RX_FRM_ERR_EN
                        check("frm_err", 32'(frm_err), 32'(!e.stop));
`endif
                    end
                end else begin
                    check("rx_data_hold", 32'(rx_data), 32'(sb_prev_data));
`ifdef UART_RX_FRM_ERR_EN
                    check("frm_err_hold", 32'(frm_err), 32'(sb_prev_fe));
`endif
                end
                if (sb_prev_rdy && !rdy) begin
                    check("rdy_drop_cause",
                        32'(sb_prev_clr || (longint'($time) - sb_last_fall <= 5 * PERIOD)), 32'(1));
                end
            end
            sb_prev_rdy  = rdy;
            sb_prev_data = rx_data;
            sb_prev_clr  = clr;
            sb_prev_rx   = rx;
`ifdef UART_RX_FRM_ERR_EN
            sb_prev_fe   = frm_err;
`endif
        end
    end

    initial begin : random_clr
        forever begin
            @(posedge clk);
            #1;
            if (rand_clr_en) begin
                clr = ($urandom_range(0, 15) == 0);
            end
        end
    end

    initial begin : watchdog
        #(PERIOD * 90000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        #1;
        rst   = 1'b1;
        rst_f = 1'b1;
        fork
            begin : fast_tests
                logic       seen;
                logic [7:0] d;
                int         kind;
                int         gap;
                logic       stop;

                @(posedge clk);
                #1;
                wait_cyc(3);
                check("init_rdy", 32'(rdy), 32'(0));
                check("init_rx_data", 32'(rx_data), 32'(8'h00));
                rst = 1'b0;
                wait_cyc(4);

                // Back-to-back burst with no idle gap
                send(8'h00, 1'b1, 0);
                send(8'hFF, 1'b1, 0);
                send(8'h55, 1'b1, 0);
                send(8'h80, 1'b1, B);
                wait_drain(20 * B);
                check("burst_last_data", 32'(rx_data), 32'(8'h80));
                wait_cyc(3 * B);
                check("rdy_sticky", 32'(rdy), 32'(1));
                clr = 1'b1;
                wait_cyc(1);
                check("clr_rdy_clears", 32'(rdy), 32'(0));
                clr = 1'b0;

                // Short low glitch is a false start: rdy cleared, data kept
                send(8'h3A, 1'b1, B);
                wait_drain(20 * B);
                check("pre_glitch_rdy", 32'(rdy), 32'(1));
                rx = 1'b0;
                wait_cyc(3);
                rx = 1'b1;
                wait_cyc(2 * B);
                check("glitch_rdy", 32'(rdy), 32'(0));
                check("glitch_rx_data", 32'(rx_data), 32'(8'h3A));

                // clr_rdy high across the completion cycle
                seen = 1'b0;
                fork
                    send(8'h96, 1'b1, B);
                    begin
                        wait_cyc(9 * B);
                        clr = 1'b1;
                        for (int k = 0; k < 2 * B && !seen; k++) begin
                            @(negedge clk);
                            if (rdy) seen = 1'b1;
                        end
                        check("set_wins_rdy", 32'(seen), 32'(1));
                        @(posedge clk);
                        #1;
                        clr = 1'b0;
                    end
                join
                wait_drain(20 * B);
                check("set_wins_data", 32'(rx_data), 32'(8'h96));

                // Reset in the middle of data bit 4 of 0x3C
                d  = 8'h3C;
                rx = 1'b0;
                wait_cyc(B);
                for (int i = 0; i < 4; i++) begin
                    rx = d[i];
                    wait_cyc(B);
                end
                rx = d[4];
                wait_cyc(B / 2);
                rst = 1'b1;
                rx  = 1'b1;
                wait_cyc(4);
                check("midreset_rdy", 32'(rdy), 32'(0));
                check("midreset_rx_data", 32'(rx_data), 32'(8'h00));
                rst = 1'b0;
                wait_cyc(12 * B);
                check("post_reset_rx_data", 32'(rx_data), 32'(8'h00));
                send(8'hC3, 1'b1, B);
                wait_drain(20 * B);
                check("after_reset_data", 32'(rx_data), 32'(8'hC3));

                // Break: line held low well past one frame
                push_exp(8'h00, 1'b0);
                rx = 1'b0;
                wait_cyc(25 * B);
                rx = 1'b1;
                wait_cyc(2 * B);
                wait_drain(20 * B);
                check("break_data", 32'(rx_data), 32'(8'h00));
                check("break_rdy", 32'(rdy), 32'(1));

`ifdef UART_RX_FRM_ERR_EN
                send(8'h5A, 1'b0, B);
                wait_drain(20 * B);
                check("fe_bad_stop_data", 32'(rx_data), 32'(8'h5A));
                check("fe_bad_stop_rdy", 32'(rdy), 32'(1));
                check("fe_bad_stop_flag", 32'(frm_err), 32'(1));
                clr = 1'b1;
                wait_cyc(1);
                clr = 1'b0;
                check("fe_kept_after_clr", 32'(frm_err), 32'(1));
                send(8'h11, 1'b1, B);
                wait_drain(20 * B);
                check("fe_good_stop_data", 32'(rx_data), 32'(8'h11));
                check("fe_good_stop_flag", 32'(frm_err), 32'(0));
`endif

                // Randomized traffic: frames, glitches, breaks, random clr_rdy
                rand_clr_en = 1'b1;
                for (int n = 0; n < 40; n++) begin
                    kind = $urandom_range(0, 9);
                    gap  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 2 * B);
                    if (kind == 0) begin
                        rx = 1'b0;
                        wait_cyc($urandom_range(1, B / 4));
                        rx = 1'b1;
                        wait_cyc(B + gap);
                    end else if (kind == 1) begin
                        push_exp(8'h00, 1'b0);
                        rx = 1'b0;
                        wait_cyc(12 * B);
                        rx = 1'b1;
                        wait_cyc(B + gap);
                    end else begin
                        stop = 1'b1;
`ifdef UART_RX_FRM_ERR_EN
                        stop = ($urandom_range(0, 4) != 0);
`endif
                        d = 8'($urandom);
                        send(d, stop, stop ? gap : (B / 2 + gap));
                    end
                end
                rand_clr_en = 1'b0;
                wait_cyc(1);
                clr = 1'b0;
                wait_drain(20 * B);
            end

            begin : full_rate_tests
                logic       seen_f;
                longint     t_fall;
                longint     t_rise;
                logic [7:0] d;

                @(posedge clk);
                #1;
                wait_cyc(3);
                check("full_reset_rdy", 32'(rdy_f), 32'(0));
                check("full_reset_data", 32'(rx_data_f), 32'(8'h00));
                rst_f = 1'b0;
                wait_cyc(4);

                d      = 8'hA5;
                seen_f = 1'b0;
                t_rise = 0;
                t_fall = longint'($time);
                fork
                    begin
                        rx_f = 1'b0;
                        wait_cyc(BF);
                        for (int i = 0; i < 8; i++) begin
                            rx_f = d[i];
                            wait_cyc(BF);
                        end
                        rx_f = 1'b1;
                        wait_cyc(BF);
                    end
                    begin
                        for (int k = 0; k < 11 * BF && !seen_f; k++) begin
                            @(negedge clk);
                            if (rdy_f) begin
                                seen_f = 1'b1;
                                t_rise = longint'($time) - PERIOD/2;
                            end
                        end
                    end
                join
                check("full_rdy_seen", 32'(seen_f), 32'(1));
                check_range("full_latency", int'((t_rise - t_fall) / PERIOD),
                            lat_model(BF) - 1, lat_model(BF) + 1);
                check("full_rx_data", 32'(rx_data_f), 32'(8'hA5));
                wait_cyc(100);
                check("full_rdy_sticky", 32'(rdy_f), 32'(1));
                clr_f = 1'b1;
                wait_cyc(1);
                check("full_clr_next_clk", 32'(rdy_f), 32'(0));
                clr_f = 1'b0;

                rx_f = 1'b0;
                wait_cyc(500);
                rx_f = 1'b1;
                wait_cyc(3000);
                check("full_glitch_rdy", 32'(rdy_f), 32'(0));
                check("full_glitch_data", 32'(rx_data_f), 32'(8'hA5));
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
